seg_scan_ctrl: RTL

Parametrised, time-multiplexed N-digit seven-segment scan controller. It generalises the fixed 4-anode rotator into a full display driver:
- configurable digit count, with a prescaled slot rate;
- anti-ghosting blanking at the start of each slot;
- per-digit enables and leading-zero suppression;
- hex decode, with a shadow register that updates the displayed value only at frame boundaries.

It sits between the servo/SPI status logic and the board's anode/cathode pins.

---
 rtl/seg_scan_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller with slot blanking,
// leading-zero suppression and a frame-synchronised shadow register.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  lz_sup,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]          p;
  logic [IW-1:0]          i;
  logic                   slot_end;
  logic                   boundary;
  logic                   wrap_d;

  logic [4*DIGITS-1:0]    sh_val;
  logic [DIGITS-1:0]      sh_dp;
  logic [DIGITS-1:0]      sh_en;
  logic                   sh_lz;
  logic                   pending;

  logic [4*DIGITS-1:0]    act_val;
  logic [DIGITS-1:0]      act_dp;
  logic [DIGITS-1:0]      act_en;
  logic                   act_lz;

  logic [DIGITS-1:0]      suppressed;
  logic                   zero_run;
  logic [3:0]             nib;
  logic                   lit;
  logic [DIGITS-1:0]      an_nxt;
  logic [6:0]             seg_nxt;
  logic                   dp_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign slot_end = (p == PW'(PRESCALE - 1));
  assign boundary = slot_end && (i == IW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      i <= '0;
    end else if (slot_end) begin
      p <= '0;
      i <= boundary ? '0 : i + 1'b1;
    end else begin
      p <= p + 1'b1;
    end
  end

  // Transfer reads the pre-load shadow, so a load on the boundary waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val  <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
      sh_lz   <= 1'b0;
      pending <= 1'b0;
      act_val <= '0;
      act_dp  <= '0;
      act_en  <= '0;
      act_lz  <= 1'b0;
    end else begin
      if (boundary && pending) begin
        act_val <= sh_val;
        act_dp  <= sh_dp;
        act_en  <= sh_en;
        act_lz  <= sh_lz;
        pending <= 1'b0;
      end
      if (load) begin
        sh_val  <= value;
        sh_dp   <= dp_in;
        sh_en   <= dig_en;
        sh_lz   <= lz_sup;
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    zero_run   = 1'b1;
    suppressed = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (act_val[4*k +: 4] == 4'h0);
      if (k > 0) suppressed[k] = act_lz && zero_run;
    end
    nib     = act_val[4*i +: 4];
    lit     = (int'(p) >= BLANK_CYC) && act_en[i] && !suppressed[i];
    an_nxt  = lit ? ~(DIGITS'(1) << i) : '1;
    seg_nxt = lit ? glyph(nib) : 7'h7F;
    dp_nxt  = lit ? ~act_dp[i] : 1'b1;
  end

  // frame_start is delayed to line up with the first registered output of slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      wrap_d      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      wrap_d      <= boundary;
      frame_start <= wrap_d;
    end
  end

endmodule
